// File: rtl/if_fetch_pkg.sv
// Shared pipeline constants and types for the instruction fetch stage.
package if_fetch_pkg;

    // Fetch PC after reset and the instruction shown in an empty IF/ID slot.
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;  // addi x0, x0, 0

    // RV32I major opcodes, shared with the decode stage.
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Fetch controller states.
    //   ST_FETCH   : no request outstanding, a request may issue
    //   ST_WAIT    : one request outstanding, its response is wanted
    //   ST_DISCARD : one request outstanding, its response must be dropped
    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_t;

    // Force an address onto a 32-bit word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/if_fetch_buffer.sv
// Two-entry in-order buffer of fetched {pc, instruction} pairs sitting
// between the instruction memory response and the IF/ID register.
// Push and pop in the same cycle both take effect; flush empties it.
module if_fetch_buffer
    import if_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_push,
    input  logic [31:0] i_push_pc,
    input  logic [31:0] i_push_instr,
    input  logic        i_pop,
    input  logic        i_flush,
    output logic        o_full,
    output logic        o_empty,
    output logic [31:0] o_head_pc,
    output logic [31:0] o_head_instr
);

    logic [31:0] r_pc_mem    [2];
    logic [31:0] r_instr_mem [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;

    logic        w_push;
    logic        w_pop;

    // Guard against underflow/overflow so the pointers can never desync.
    assign w_pop  = i_pop  && (r_count != 2'd0);
    assign w_push = i_push && (r_count != 2'd2);

    // Pointer and occupancy bookkeeping; flush has priority over push/pop.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk) begin
        if (w_push && !i_flush && !rst) begin
            r_pc_mem[r_wr_ptr]    <= i_push_pc;
            r_instr_mem[r_wr_ptr] <= i_push_instr;
        end
    end

    assign o_full       = (r_count == 2'd2);
    assign o_empty      = (r_count == 2'd0);
    assign o_head_pc    = r_pc_mem[r_rd_ptr];
    assign o_head_instr = r_instr_mem[r_rd_ptr];

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: issues word-aligned requests to instruction
// memory (one outstanding at most), collects responses into a 2-entry
// buffer and feeds the IF/ID pipeline register.
//
// Handshakes: a request transfers on a rising edge where imem_req_valid
// and imem_req_ready are both high; imem_req_valid may drop before that
// (withdrawal on redirect). A response transfers on any rising edge where
// imem_resp_valid is high; there is no backpressure on the response side.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        EX_redirect,
    input  logic [31:0] EX_redirect_target,
    input  logic        ID_stall,
    output logic [31:0] IF_ID_instruction,
    output logic [31:0] IF_ID_pc,
    output logic        IF_ID_valid
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;

    logic [31:0] r_pc;          // next address to request
    logic [31:0] r_req_pc;      // address of the outstanding request
    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pc;
    logic        r_ifid_valid;

    logic        w_req_valid;
    logic        w_hs;
    logic        w_push;
    logic        w_pop;
    logic        w_buf_full;
    logic        w_buf_empty;
    logic [31:0] w_head_pc;
    logic [31:0] w_head_instr;

    // Only ST_FETCH can issue, and only when the response is guaranteed a
    // buffer slot (no request is outstanding in ST_FETCH, so a non-full
    // buffer is enough). A redirect cycle withdraws any pending request.
    assign w_req_valid = (r_state == ST_FETCH) && !w_buf_full && !EX_redirect && !rst;
    assign w_hs        = w_req_valid && imem_req_ready;

    // A response is kept only when it was wanted and no flush is happening.
    assign w_push = (r_state == ST_WAIT) && imem_resp_valid && !EX_redirect;
    // Pop when ID can take a new instruction; a redirect drops everything.
    assign w_pop  = !ID_stall && !EX_redirect && !w_buf_empty;

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_pc;

    // Next-state logic for the request/response tracker.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FETCH: begin
                if (w_hs) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_resp_valid)  w_state_nxt = ST_FETCH;
                else if (EX_redirect) w_state_nxt = ST_DISCARD;
            end
            ST_DISCARD: begin
                if (imem_resp_valid) w_state_nxt = ST_FETCH;
            end
            default: w_state_nxt = ST_FETCH;
        endcase
    end

    // State register; reset abandons any outstanding request.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_FETCH;
        else     r_state <= w_state_nxt;
    end

    // Fetch PC: redirect wins over sequential advance on handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_req_pc <= RESET_PC;
        end else if (EX_redirect) begin
            r_pc <= word_align(EX_redirect_target);
        end else if (w_hs) begin
            r_pc     <= r_pc + 32'd4;
            r_req_pc <= r_pc;
        end
    end

    // IF/ID register: redirect clears, stall holds, otherwise take the head.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ifid_valid <= 1'b0;
            r_ifid_pc    <= 32'd0;
            r_ifid_instr <= NOP_INSTR;
        end else if (EX_redirect) begin
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= NOP_INSTR;
        end else if (!ID_stall) begin
            if (!w_buf_empty) begin
                r_ifid_valid <= 1'b1;
                r_ifid_pc    <= w_head_pc;
                r_ifid_instr <= w_head_instr;
            end else begin
                r_ifid_valid <= 1'b0;
                r_ifid_instr <= NOP_INSTR;
            end
        end
    end

    assign IF_ID_valid       = r_ifid_valid;
    assign IF_ID_pc          = r_ifid_pc;
    assign IF_ID_instruction = r_ifid_instr;

    if_fetch_buffer u_buffer (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_push_pc    (r_req_pc),
        .i_push_instr (imem_resp_data),
        .i_pop        (w_pop),
        .i_flush      (EX_redirect),
        .o_full       (w_buf_full),
        .o_empty      (w_buf_empty),
        .o_head_pc    (w_head_pc),
        .o_head_instr (w_head_instr)
    );

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: IF_fetch

Interface
REQ-001 Parameters SHALL be: RESET_PC, 32'h0000_0000, PC loaded on reset; NOP_INSTR, 32'h0000_0013, instruction presented when slot invalid.
REQ-002 Ports SHALL be (name direction width meaning):
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- imem_req_valid  out  1  fetch request
- imem_req_addr  out  32  word-aligned fetch address
- imem_req_ready  in  1  memory accepts request
- imem_resp_valid  in  1  instruction returned
- imem_resp_data  in  32  instruction word
- EX_redirect  in  1  taken branch/jump, flush
- EX_redirect_target  in  32  new PC
- ID_stall  in  1  hold IF/ID register
- IF_ID_instruction  out  32  instruction to ID
- IF_ID_pc  out  32  PC of IF_ID_instruction
- IF_ID_valid  out  1  IF/ID slot holds real instruction
REQ-003 One clock and a synchronous, active-high reset SHALL be used, with ports named clk and rst.

Function
REQ-004 The FSM SHALL have states FETCH (request may issue), WAIT (one request outstanding), DISCARD (outstanding response to be dropped).
REQ-005 At most one request SHALL be outstanding; handshake = imem_req_valid && imem_req_ready on a rising edge.
REQ-006 imem_req_valid SHALL be high only in FETCH with buffer occupancy + outstanding < 2, and SHALL be low during rst and in the cycle EX_redirect is high.
REQ-007 imem_req_addr SHALL equal fetch PC; the PC SHALL advance by 4 on handshake; imem_req_addr[1:0] SHALL be 2'b00.
REQ-008 FETCH->WAIT on handshake; WAIT->FETCH on imem_resp_valid; DISCARD->FETCH on imem_resp_valid with the data dropped.
REQ-009 Response latency SHALL be accepted at >=1 cycle after handshake, unbounded.
REQ-010 Each accepted response SHALL push {pc, instr} into a 2-entry in-order fetch buffer; no push SHALL occur when full (guaranteed by REQ-006).
REQ-011 When !ID_stall: if buffer non-empty, IF/ID SHALL load head and pop with IF_ID_valid=1; else IF_ID_valid=0.
REQ-012 When ID_stall and no redirect, IF_ID_instruction, IF_ID_pc, IF_ID_valid and the buffer head SHALL hold; fetching SHALL continue until the buffer is full.
REQ-013 Whenever IF_ID_valid=0, IF_ID_instruction SHALL read NOP_INSTR.
REQ-014 EX_redirect SHALL take priority over ID_stall: next cycle fetch PC = EX_redirect_target, buffer emptied, IF_ID_valid=0.
REQ-015 Redirect in WAIT without same-cycle response SHALL go to DISCARD; redirect in WAIT with same-cycle response SHALL drop the data and go to FETCH.
REQ-016 Redirect in DISCARD SHALL stay in DISCARD, or go to FETCH if a response arrives that cycle.
REQ-017 A request pending but not yet accepted SHALL be withdrawn on redirect; the imem protocol permits withdrawal.
REQ-018 Buffer-pop and push in the same cycle SHALL both take effect, with occupancy unchanged.
REQ-019 Unaligned EX_redirect_target SHALL be truncated to a word boundary.

Reset
REQ-020 On rst: fetch PC=RESET_PC, state=FETCH, buffer empty, IF_ID_valid=0, IF_ID_pc=0, IF_ID_instruction=NOP_INSTR, imem_req_valid=0.
REQ-021 rst mid-transaction SHALL abandon any outstanding request; a response arriving after rst deasserts SHALL be ignored until the first post-reset handshake.

Structure
REQ-022 RESET_PC, NOP_INSTR and the opcode constants SHALL be placed in a shared pipeline include header.
REQ-023 The 2-entry buffer SHALL be the sub-module IF_fetch_buffer (push, pop, flush, full, empty, head), instantiated once.

Verification
REQ-024 rst then 1-cycle-latency memory, no stall -> addresses 0x0,0x4,0x8; IF_ID_pc sequence 0x0,0x4,0x8 with IF_ID_valid=1.
REQ-025 ID_stall high for 5 cycles -> IF_ID held; exactly 2 further requests issued; on release, PCs continue with no gap or duplicate.
REQ-026 EX_redirect to 0x100 while WAIT, response 3 cycles later -> that response dropped; next handshake addr 0x100; IF_ID_valid=0 until the 0x100 instruction is loaded.
REQ-027 EX_redirect and ID_stall high together -> IF_ID_valid=0, IF_ID_instruction=0x00000013 next cycle.
REQ-028 imem_req_ready low 4 cycles, then redirect to 0x200 -> the 0x8 request is withdrawn and the next accepted address is 0x200.
REQ-029 rst asserted while WAIT -> next handshake addr 0x0; stale response ignored.
